// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: period-synchronous RGB PWM with steady/blink/breathe/off modes.
// SB_RGBA_DRV below is a behavioural stand-in for the iCE40 LED driver.
module SB_RGBA_DRV #(
    parameter string RGB0_CURRENT = "0b000000",
    parameter string RGB1_CURRENT = "0b000000",
    parameter string RGB2_CURRENT = "0b000000"
) (
    input  logic CURREN,
    input  logic RGBLEDEN,
    input  logic RGB0PWM,
    input  logic RGB1PWM,
    input  logic RGB2PWM,
    output logic RGB0,
    output logic RGB1,
    output logic RGB2
);
    localparam bit ON0 = RGB0_CURRENT != "0b000000";
    localparam bit ON1 = RGB1_CURRENT != "0b000000";
    localparam bit ON2 = RGB2_CURRENT != "0b000000";
    assign RGB0 = CURREN & RGBLEDEN & RGB0PWM & ON0;
    assign RGB1 = CURREN & RGBLEDEN & RGB1PWM & ON1;
    assign RGB2 = CURREN & RGBLEDEN & RGB2PWM & ON2;
endmodule

module rgb_pwm_sequencer #(
    parameter int    PWM_BITS    = 8,
    parameter int    TICK_DIV    = 1,
    parameter int    STEP_DIV    = 256,
    parameter string LED_CURRENT = "0b010"
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PWM_BITS-1:0] cfg_red,
    input  logic [PWM_BITS-1:0] cfg_green,
    input  logic [PWM_BITS-1:0] cfg_blue,
    input  logic [1:0]          cfg_mode,
    output logic [2:0]          pwm_out,
    output logic                period_end,
    output logic                led_red,
    output logic                led_green,
    output logic                led_blue
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX = '1;

    typedef enum logic [1:0] {STEADY, BLINK, BREATHE, OFF} mode_t;

    logic [PW-1:0]                 pre;
    logic [SW-1:0]                 step;
    logic [PWM_BITS-1:0]           cnt, scale;
    logic [2:0][PWM_BITS-1:0]      lvl, pend_lvl, eff;
    mode_t                         mode, pend_mode;
    logic                          pending, down, phase_off;
    logic                          tick, wrap, step_ev, apply, new_mode;

    assign tick      = pre == PW'(TICK_DIV - 1);
    assign wrap      = tick && cnt == MAX;
    assign step_ev   = wrap && step == SW'(STEP_DIV - 1);
    assign apply     = wrap && pending;
    assign new_mode  = apply && pend_mode != mode;
    assign cfg_ready = !pending;

    // Breathe keeps the top half of level*scale so full scale never reaches full on.
    always_comb begin
        eff = '0;
        for (int i = 0; i < 3; i++)
            eff[i] = mode == STEADY  ? lvl[i] :
                     mode == BLINK   ? (phase_off ? '0 : lvl[i]) :
                     mode == BREATHE ? PWM_BITS'(({{PWM_BITS{1'b0}}, lvl[i]} * {{PWM_BITS{1'b0}}, scale}) >> PWM_BITS) :
                                       '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre        <= '0;
            cnt        <= '0;
            step       <= '0;
            scale      <= '0;
            lvl        <= '0;
            pend_lvl   <= '0;
            mode       <= OFF;
            pend_mode  <= OFF;
            pending    <= 1'b0;
            down       <= 1'b0;
            phase_off  <= 1'b0;
            pwm_out    <= '0;
            period_end <= 1'b0;
        end else begin
            pre        <= tick ? '0 : pre + 1'b1;
            if (tick) cnt <= cnt + 1'b1;
            period_end <= wrap;
            pwm_out    <= {cnt < eff[2], cnt < eff[1], cnt < eff[0]};
            if (apply) begin
                lvl     <= pend_lvl;
                mode    <= pend_mode;
                pending <= 1'b0;
            end else if (cfg_valid && !pending) begin
                pend_lvl  <= {cfg_blue, cfg_green, cfg_red};
                pend_mode <= mode_t'(cfg_mode);
                pending   <= 1'b1;
            end
            // A mode change restarts the animation; re-applying the same mode does not.
            if (new_mode) begin
                step      <= '0;
                scale     <= '0;
                down      <= 1'b0;
                phase_off <= 1'b0;
            end else begin
                if (wrap) step <= step_ev ? '0 : step + 1'b1;
                if (step_ev) begin
                    phase_off <= !phase_off;
                    if (!down) begin
                        if (scale == MAX) down <= 1'b1;
                        else scale <= scale + 1'b1;
                    end else begin
                        if (scale == '0) down <= 1'b0;
                        else scale <= scale - 1'b1;
                    end
                end
            end
        end
    end

    SB_RGBA_DRV #(
        .RGB0_CURRENT(LED_CURRENT),
        .RGB1_CURRENT(LED_CURRENT),
        .RGB2_CURRENT(LED_CURRENT)
    ) drv (
        .CURREN  (1'b1),
        .RGBLEDEN(1'b1),
        .RGB0PWM (pwm_out[1]),
        .RGB1PWM (pwm_out[2]),
        .RGB2PWM (pwm_out[0]),
        .RGB0    (led_green),
        .RGB1    (led_blue),
        .RGB2    (led_red)
    );
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb_rgb_pwm_sequencer: directed plus random stimulus against a period-level reference model.
module tb_rgb_pwm_sequencer;
    localparam int W  = 4;
    localparam int SD = 2;
    localparam int P  = 1 << W;

    logic         clk = 0, rst_n = 0, cfg_valid = 0;
    logic [W-1:0] cfg_red = 0, cfg_green = 0, cfg_blue = 0;
    logic [1:0]   cfg_mode = 0;
    logic         cfg_ready, period_end, led_red, led_green, led_blue;
    logic [2:0]   pwm_out;

    rgb_pwm_sequencer #(.PWM_BITS(W), .TICK_DIV(1), .STEP_DIV(SD), .LED_CURRENT("0b010")) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_red(cfg_red), .cfg_green(cfg_green), .cfg_blue(cfg_blue), .cfg_mode(cfg_mode),
        .pwm_out(pwm_out), .period_end(period_end),
        .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    // Reference model: position in period, periods since the animation restarted, active and pending config.
    int c, per, m_mode, p_mode;
    int lvl[3], p_lvl[3];
    bit pend, xfer;

    function automatic int eff(int l);
        int k = per / SD;
        int s = (k % (2 * P) < P) ? k % (2 * P) : 2 * P - 1 - k % (2 * P);
        case (m_mode)
            0: return l;
            1: return (k % 2 == 0) ? l : 0;
            2: return (l * s) >> W;
            default: return 0;
        endcase
    endfunction

    task automatic cyc();
        logic [2:0] ep;
        logic epe;
        @(posedge clk);
        xfer = 0;
        if (!rst_n) begin
            c = 0; per = 0; m_mode = 3; lvl = '{0, 0, 0}; pend = 0;
            ep = 0; epe = 0;
        end else begin
            for (int i = 0; i < 3; i++) ep[i] = c < eff(lvl[i]);
            epe = c == P - 1;
            if (c == P - 1) per++;
            if (c == P - 1 && pend) begin
                if (p_mode != m_mode) per = 0;
                m_mode = p_mode; lvl = p_lvl; pend = 0;
            end else if (cfg_valid && !pend) begin
                xfer = 1; pend = 1; p_mode = int'(cfg_mode);
                p_lvl = '{int'(cfg_red), int'(cfg_green), int'(cfg_blue)};
            end
            c = (c + 1) % P;
        end
        #1;
        checks++;
        assert (pwm_out === ep) else begin errors++; $error("FAIL pwm_out obs=%b exp=%b t=%0t", pwm_out, ep, $time); end
        checks++;
        assert (period_end === epe) else begin errors++; $error("FAIL period_end obs=%b exp=%b t=%0t", period_end, epe, $time); end
        checks++;
        assert (cfg_ready === !pend) else begin errors++; $error("FAIL cfg_ready obs=%b exp=%b t=%0t", cfg_ready, !pend, $time); end
        checks++;
        assert ({led_blue, led_green, led_red} === ep) else begin errors++; $error("FAIL leds obs=%b exp=%b t=%0t", {led_blue, led_green, led_red}, ep, $time); end
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic offer(int r, int g, int b, int md);
        cfg_red = W'(r); cfg_green = W'(g); cfg_blue = W'(b); cfg_mode = 2'(md);
        cfg_valid = 1;
        xfer = 0;
        for (int i = 0; i < 4 * P && !xfer; i++) cyc();
        cfg_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        run(2);
        rst_n = 1;
        run(64);
        offer(4, 0, 15, 0);
        run(3 * P);
        offer(4, 0, 0, 0);
        for (int i = 0; i < 4 * P && c != 5; i++) cyc();
        offer(12, 0, 0, 0);
        offer(7, 3, 9, 0);
        run(3 * P);
        offer(8, 0, 0, 1);
        run(8 * P);
        offer(8, 0, 0, 0);
        run(3 * P);
        offer(15, 0, 0, 2);
        run(2 * SD * P * (P + 4));
        offer(5, 5, 5, 0);
        rst_n = 0;
        cyc();
        rst_n = 1;
        run(4 * P);
        for (int n = 0; n < 30; n++) begin
            run($urandom_range(40, 0));
            offer($urandom_range(P - 1, 0), $urandom_range(P - 1, 0), $urandom_range(P - 1, 0), $urandom_range(3, 0));
        end
        run(8 * P);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
